fifo_port_arbiter: RTL and testbench

Write-side arbiter and read-side sequencer for the shared 16-bit FIFO. It grants one of NREQ producers per cycle in round-robin order and tracks occupancy internally, so it never relies on the FIFO's late registered full flag. On the read side it issues pops, tags the FIFO's registered output with a valid strobe, and runs a flush sequence. It sits between the producer ports and the FIFO's new_data/inData/out_data/outData pins.

---
 rtl/fifo_port_arbiter_pkg.sv | 19 +
 rtl/fifo_port_arbiter_if.sv | 32 +++
 rtl/fifo_port_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_port_arbiter.sv | 100 ++++++++++
 tb/tb_fifo_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_port_arbiter_pkg.sv
// Shared types and helpers for the FIFO write arbiter / read sequencer.
package fifo_port_arbiter_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Ceiling log2, never below 1 so a pointer always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_port_arbiter_if.sv
// Producer, FIFO-pin and consumer signals of the arbiter bundled as one port.
interface fifo_port_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = 5
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  fifo_new_data;
  logic [WIDTH-1:0]      fifo_in_data;
  logic                  pop_req;
  logic                  fifo_out_data;
  logic [WIDTH-1:0]      fifo_rd_data;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  flush;
  logic [CNTW-1:0]       count;
  logic                  busy;

  modport slave (
    input  req, req_data, pop_req, fifo_rd_data, flush,
    output gnt, fifo_new_data, fifo_in_data, fifo_out_data,
           out_data, out_valid, count, busy
  );

  modport master (
    output req, req_data, pop_req, fifo_rd_data, flush,
    input  gnt, fifo_new_data, fifo_in_data, fifo_out_data,
           out_data, out_valid, count, busy
  );
endinterface

// File: rtl/fifo_port_arbiter_rr_pick.sv
// Round-robin picker: first requester after the last-grant pointer wins.
module fifo_port_arbiter_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LGW  = 2
) (
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  input  logic [LGW-1:0]  lg_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [LGW-1:0]  win_o
);

  always_comb begin
    logic           found;
    logic [LGW-1:0] idx;
    gnt_o = '0;
    win_o = lg_i;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = LGW'((32'(lg_i) + k) % NREQ);
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Write-side round-robin arbiter and read-side pop/flush sequencer for the shared FIFO.
// Occupancy is tracked locally so writes never depend on the FIFO's late full flag.
module fifo_port_arbiter
  import fifo_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 5
) (
  input logic                  clock,
  input logic                  reset,
  fifo_port_arbiter_if.slave   bus_io
);

  localparam int unsigned LGW = clog2(NREQ);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [LGW-1:0]   lg_q, lg_d;
  logic             out_valid_q, out_valid_d;

  logic             run_mode;
  logic             space;
  logic             wr;
  logic             pop;
  logic [NREQ-1:0]  gnt;
  logic [LGW-1:0]   win;
  logic [WIDTH-1:0] in_data;

  // A flush pulse switches behaviour in its own cycle, before the state register follows.
  assign run_mode = (state_q == RUN) && !bus_io.flush;
  assign space    = reset && run_mode && (count_q < CNTW'(DEPTH));
  assign wr       = |gnt;
  assign pop      = reset && (count_q != '0) && (run_mode ? bus_io.pop_req : 1'b1);

  fifo_port_arbiter_rr_pick #(
    .NREQ (NREQ),
    .LGW  (LGW)
  ) u_rr_pick (
    .en_i  (space),
    .req_i (bus_io.req),
    .lg_i  (lg_q),
    .gnt_o (gnt),
    .win_o (win)
  );

  // One-hot AND-OR mux of the granted producer's data.
  always_comb begin
    in_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) in_data = in_data | bus_io.req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    count_d     = count_q;
    lg_d        = lg_q;
    state_d     = state_q;
    out_valid_d = pop && run_mode;

    if (wr && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (pop && !wr) begin
      count_d = count_q - CNTW'(1);
    end

    if (wr) lg_d = win;

    case (state_q)
      RUN:     if (bus_io.flush) state_d = FLUSH;
      FLUSH:   if (count_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= RUN;
      count_q     <= '0;
      lg_q        <= LGW'(NREQ - 1);
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lg_q        <= lg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus_io.gnt           = gnt;
  assign bus_io.fifo_new_data = wr;
  assign bus_io.fifo_in_data  = in_data;
  assign bus_io.fifo_out_data = pop;
  assign bus_io.out_data      = bus_io.fifo_rd_data;
  assign bus_io.out_valid     = out_valid_q;
  assign bus_io.count         = count_q;
  assign bus_io.busy          = (state_q == FLUSH);

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Bench for fifo_port_arbiter: queue-based occupancy/ordering model, directed scenarios, random traffic.
module tb_fifo_port_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNTW  = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fifo_port_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  fifo_port_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_io (bus)
  );

  // Stand-in for the real FIFO: registered read data, shares the reset.
  logic [WIDTH-1:0] fifo_mem[$];
  always @(posedge clock) begin
    if (!reset) begin
      fifo_mem.delete();
      bus.fifo_rd_data <= '0;
    end else begin
      if (bus.fifo_out_data && fifo_mem.size() > 0) bus.fifo_rd_data <= fifo_mem.pop_front();
      if (bus.fifo_new_data) fifo_mem.push_back(bus.fifo_in_data);
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, occupancy = queue size.
  int               m_lg    = NREQ - 1;
  bit               m_busy  = 1'b0;
  bit               m_valid = 1'b0;
  bit               m_known = 1'b0;
  logic [WIDTH-1:0] m_word  = '0;
  logic [WIDTH-1:0] m_q[$];

  logic [NREQ-1:0]  obs_gnt;
  logic             obs_valid, obs_busy, obs_pop, obs_new;
  logic [WIDTH-1:0] obs_data, obs_in;
  logic [CNTW-1:0]  obs_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    bit               flushing, e_pop;
    int               win;
    logic [WIDTH-1:0] e_in, w;
    @(negedge clock);
    flushing = m_busy || bus.flush;
    win = -1;
    if (reset && !flushing && m_q.size() < DEPTH) begin
      for (int k = 1; k <= NREQ; k++) begin
        int p;
        p = (m_lg + k) % NREQ;
        if (win < 0 && bus.req[p]) win = p;
      end
    end
    e_in  = (win >= 0) ? bus.req_data[win*WIDTH +: WIDTH] : '0;
    e_pop = reset && (m_q.size() > 0) && (flushing || bus.pop_req);

    chk("gnt", 32'(bus.gnt), (win >= 0) ? (32'd1 << win) : 32'd0);
    chk("fifo_new_data", 32'(bus.fifo_new_data), 32'(win >= 0));
    chk("fifo_in_data", 32'(bus.fifo_in_data), 32'(e_in));
    chk("fifo_out_data", 32'(bus.fifo_out_data), 32'(e_pop));
    if (m_known) begin
      chk("count", 32'(bus.count), 32'(m_q.size()));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) chk("out_data", 32'(bus.out_data), 32'(m_word));
    end

    obs_gnt = bus.gnt;  obs_valid = bus.out_valid; obs_busy = bus.busy;
    obs_pop = bus.fifo_out_data; obs_new = bus.fifo_new_data;
    obs_data = bus.out_data; obs_in = bus.fifo_in_data; obs_count = bus.count;

    @(posedge clock);
    if (!reset) begin
      m_q.delete();
      m_lg = NREQ - 1; m_busy = 1'b0; m_valid = 1'b0; m_known = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (e_pop) begin
        w = m_q.pop_front();
        if (!flushing) begin
          m_valid = 1'b1;
          m_word  = w;
        end
      end
      if (win >= 0) begin
        m_q.push_back(e_in);
        m_lg = win;
      end
      if (!m_busy) m_busy = bus.flush;
      else         m_busy = (m_q.size() != 0);
    end
    #1;
  endtask

  task automatic set_port_data(input int base);
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = WIDTH'(base + i);
  endtask

  // Pulse flush, then run until busy has risen and fallen again; report what happened meanwhile.
  task automatic flush_drain(output int grants, output int valids, output logic [NREQ-1:0] first_gnt);
    bit seen;
    seen = 1'b0; grants = 0; valids = 0; first_gnt = '0;
    bus.flush = 1'b1;
    cycle();
    if (obs_new) grants++;
    if (obs_valid) valids++;
    bus.flush = 1'b0;
    for (int n = 0; n < 64; n++) begin
      cycle();
      if (obs_busy) seen = 1'b1;
      if (!obs_busy && seen) begin
        first_gnt = obs_gnt;
        return;
      end
      if (obs_new) grants++;
      if (obs_valid) valids++;
    end
    chk("flush_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int               n, grants, valids;
    logic [NREQ-1:0]  fg;

    bus.req = '0; bus.req_data = '0; bus.pop_req = 1'b0; bus.flush = 1'b0;
    reset = 1'b0;
    repeat (3) cycle();
    reset = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("idle_count", 32'(obs_count), 32'd0);
      chk("idle_valid", 32'(obs_valid), 32'd0);
      chk("idle_gnt", 32'(obs_gnt), 32'd0);
    end

    // All ports requesting: strict rotation starting at port 0.
    set_port_data(32'h1000);
    bus.req = '1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("rr_seq", 32'(obs_gnt), 32'd1 << (c % 4));
    end
    bus.req = '0;
    cycle();
    chk("rr_count", 32'(obs_count), 32'd8);

    // Drain in order: 0x1000..0x1003 twice.
    n = 0;
    bus.pop_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) bus.pop_req = 1'b0;
      cycle();
      if (obs_valid) begin
        chk("drain_word", 32'(obs_data), 32'h1000 + 32'(n % 4));
        n++;
      end
    end
    chk("drain_words", 32'(n), 32'd8);

    // Fill to DEPTH from port 2, then one pop opens a slot a cycle later.
    bus.req = 4'b0100;
    repeat (DEPTH) cycle();
    cycle();
    chk("full_gnt", 32'(obs_gnt), 32'd0);
    chk("full_count", 32'(obs_count), 32'd16);
    bus.pop_req = 1'b1;
    cycle();
    chk("full_pop_gnt", 32'(obs_gnt), 32'd0);
    chk("full_pop_strobe", 32'(obs_pop), 32'd1);
    bus.pop_req = 1'b0;
    cycle();
    chk("after_pop_count", 32'(obs_count), 32'd15);
    chk("after_pop_gnt", 32'(obs_gnt), 32'd4);
    bus.req = '0;
    flush_drain(grants, valids, fg);
    chk("flush16_valids", 32'(valids), 32'd0);

    // Simultaneous write and pop at count 5.
    bus.req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      bus.req_data[0 +: WIDTH] = WIDTH'(32'h5000 + k);
      cycle();
    end
    bus.req = 4'b0010;
    bus.req_data[WIDTH +: WIDTH] = 16'h5100;
    bus.pop_req = 1'b1;
    cycle();
    chk("wp_count_before", 32'(obs_count), 32'd5);
    bus.req = '0; bus.pop_req = 1'b0;
    cycle();
    chk("wp_count_after", 32'(obs_count), 32'd5);
    chk("wp_valid", 32'(obs_valid), 32'd1);
    chk("wp_word", 32'(obs_data), 32'h5000);

    // Bring to 6 from port 0, then flush with everyone requesting.
    bus.req = 4'b0001;
    bus.req_data[0 +: WIDTH] = 16'h5006;
    cycle();
    bus.req = '0;
    cycle();
    chk("pre_flush_count", 32'(obs_count), 32'd6);
    bus.req = '1;
    flush_drain(grants, valids, fg);
    chk("flush_grants", 32'(grants), 32'd0);
    chk("flush_valids", 32'(valids), 32'd0);
    chk("flush_count", 32'(obs_count), 32'd0);
    chk("flush_resume_gnt", 32'(fg), 32'd2);
    bus.req = '0;
    bus.pop_req = 1'b1;
    cycle();
    bus.pop_req = 1'b0;
    cycle();

    // Pop on empty, then reset mid-stream at count 9.
    bus.pop_req = 1'b1;
    cycle();
    chk("empty_pop", 32'(obs_pop), 32'd0);
    chk("empty_count", 32'(obs_count), 32'd0);
    bus.pop_req = 1'b0;
    bus.req = '1;
    repeat (9) cycle();
    bus.req = '1; bus.pop_req = 1'b1;
    reset = 1'b0;
    cycle();
    chk("rst_count_before", 32'(obs_count), 32'd9);
    chk("rst_gnt", 32'(obs_gnt), 32'd0);
    chk("rst_pop", 32'(obs_pop), 32'd0);
    chk("rst_in_data", 32'(obs_in), 32'd0);
    reset = 1'b1; bus.pop_req = 1'b0;
    cycle();
    chk("post_rst_count", 32'(obs_count), 32'd0);
    chk("post_rst_valid", 32'(obs_valid), 32'd0);
    chk("post_rst_gnt", 32'(obs_gnt), 32'd1);
    bus.req = '0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.req      = NREQ'($urandom_range(0, 15));
      bus.req_data = {$urandom(), $urandom()};
      bus.pop_req  = ($urandom_range(0, 9) < 4);
      bus.flush    = ($urandom_range(0, 59) == 0);
      reset        = ($urandom_range(0, 399) != 0);
      cycle();
    end
    reset = 1'b1; bus.req = '0; bus.pop_req = 1'b0; bus.flush = 1'b0;
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
